// File: rtl/mac_seq_ctrl_pkg.sv
// Shared constants for the MAC sequencer: widths, mode encodings, config bit layout and FSM states.
package mac_seq_ctrl_pkg;

  localparam int unsigned MAC_MIN_WIDTH  = 8;
  localparam int unsigned MAC_ACC_WIDTH  = 32;
  localparam int unsigned MAC_CONF_WIDTH = 3;
  localparam int unsigned MAC_CNT_WIDTH  = 8;
  localparam int unsigned MAC_LAT        = 1;

  localparam logic [1:0] MAC_SINGLE  = 2'b00;
  localparam logic [1:0] MAC_DUAL    = 2'b01;
  localparam logic [1:0] MAC_QUAD    = 2'b10;
  localparam logic [1:0] MAC_ILLEGAL = 2'b11;

  // Config word layout: [1:0] mode, [2] accumulate select, above that the init value.
  localparam int unsigned MAC_ACC_SEL_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mac_seq_beat_cnt.sv
// Loadable down-counter with a last flag; used for both beat counting and output-latency waiting.
module mac_seq_beat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last_c
);

  logic [W-1:0] cnt;

  // Saturates at zero so a full-scale load counts all the way down without wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last_c = (cnt == W'(1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one MAC instance: latch job, pulse clear, stream beats, wait out latency, return result.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned MIN_W  = MAC_MIN_WIDTH,
  parameter int unsigned ACC_W  = MAC_ACC_WIDTH,
  parameter int unsigned CONF_W = MAC_CONF_WIDTH,
  parameter int unsigned CNT_W  = MAC_CNT_WIDTH,
  parameter int unsigned LAT    = MAC_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_mode,
  input  logic                    cmd_acc,
  input  logic [ACC_W-1:0]        cmd_init,
  input  logic [CNT_W-1:0]        cmd_count,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [4*MIN_W-1:0]      op_a,
  input  logic [MIN_W-1:0]        op_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        res_data,
  output logic                    res_err,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [4*MIN_W-1:0]      mac_a,
  output logic [MIN_W-1:0]        mac_b,
  output logic [ACC_W+CONF_W-1:0] mac_cfg,
  input  logic [ACC_W-1:0]        mac_c,
  output logic                    busy
);

  localparam int unsigned LAT_W = $clog2(LAT + 1);

  seq_state_e state, state_n;
  logic       cmd_fire_c, job_skip_c;
  logic       beat_load, beat_dec, beat_last_c;
  logic       lat_load, lat_dec, lat_last_c;

  assign cmd_fire_c = cmd_valid && (state == ST_IDLE);
  assign job_skip_c = (cmd_mode == MAC_ILLEGAL) || (cmd_count == '0);

  mac_seq_beat_cnt #(.W(CNT_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (beat_load),
    .load_val (cmd_count),
    .dec      (beat_dec),
    .last_c   (beat_last_c)
  );

  mac_seq_beat_cnt #(.W(LAT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_W'(LAT)),
    .dec      (lat_dec),
    .last_c   (lat_last_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    beat_load = 1'b0;
    beat_dec  = 1'b0;
    lat_load  = 1'b0;
    lat_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire_c) begin
          beat_load = 1'b1;
          state_n   = job_skip_c ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: state_n = ST_RUN;
      ST_RUN: begin
        if (op_valid) begin
          beat_dec = 1'b1;
          if (beat_last_c) begin
            lat_load = 1'b1;
            state_n  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        lat_dec = 1'b1;
        if (lat_last_c) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake/status outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_ready <= 1'b1;
      op_ready  <= 1'b0;
      mac_clr   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_ready <= (state_n == ST_IDLE);
      op_ready  <= (state_n == ST_RUN);
      mac_clr   <= (state_n == ST_LOAD);
      res_valid <= (state_n == ST_DONE);
      busy      <= (state_n != ST_IDLE);
    end
  end

  // Job config and result registers; skipped jobs resolve their result at accept time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mac_cfg  <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire_c) begin
            if (cmd_mode == MAC_ILLEGAL) begin
              res_data <= '0;
              res_err  <= 1'b1;
            end else if (cmd_count == '0) begin
              res_data <= cmd_acc ? cmd_init : '0;
              res_err  <= 1'b0;
            end else begin
              mac_cfg <= (ACC_W+CONF_W)'({cmd_init, cmd_acc, cmd_mode});
            end
          end
        end
        ST_DRAIN: begin
          if (lat_last_c) res_data <= mac_c;
        end
        ST_DONE: begin
          if (res_ready) begin
            mac_cfg  <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mac_en = op_ready && op_valid;
  assign mac_a  = op_ready ? op_a : '0;
  assign mac_b  = op_ready ? op_b : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural single-cycle MAC model driving mac_c.
module tb_mac_seq_ctrl;
  import mac_seq_ctrl_pkg::*;

  localparam int unsigned MIN_W  = MAC_MIN_WIDTH;
  localparam int unsigned ACC_W  = MAC_ACC_WIDTH;
  localparam int unsigned CONF_W = MAC_CONF_WIDTH;
  localparam int unsigned CNT_W  = MAC_CNT_WIDTH;
  localparam int unsigned LAT    = MAC_LAT;

  logic                    clk;
  logic                    rst;
  logic                    cmd_valid, cmd_ready;
  logic [1:0]              cmd_mode;
  logic                    cmd_acc;
  logic [ACC_W-1:0]        cmd_init;
  logic [CNT_W-1:0]        cmd_count;
  logic                    op_valid, op_ready;
  logic [4*MIN_W-1:0]      op_a;
  logic [MIN_W-1:0]        op_b;
  logic                    res_valid, res_ready;
  logic [ACC_W-1:0]        res_data;
  logic                    res_err;
  logic                    mac_en, mac_clr;
  logic [4*MIN_W-1:0]      mac_a;
  logic [MIN_W-1:0]        mac_b;
  logic [ACC_W+CONF_W-1:0] mac_cfg;
  logic [ACC_W-1:0]        mac_c;
  logic                    busy;

  int total = 0;
  int bad   = 0;
  int cyc = 0, en_total = 0, clr_total = 0, last_en_cyc = 0;

  mac_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_acc(cmd_acc),
    .cmd_init(cmd_init), .cmd_count(cmd_count),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_cfg(mac_cfg),
    .mac_c(mac_c), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: lane products selected by mode, clear loads init, output one cycle later.
  logic [ACC_W-1:0] model_acc = '0;
  logic [ACC_W-1:0] prod;
  always_comb begin
    prod = ACC_W'(mac_a[31:24]) * ACC_W'(mac_b);
    if (mac_cfg[1:0] == MAC_DUAL)
      prod = (ACC_W'(mac_a[31:24]) + ACC_W'(mac_a[23:16])) * ACC_W'(mac_b);
    else if (mac_cfg[1:0] == MAC_QUAD)
      prod = (ACC_W'(mac_a[31:24]) + ACC_W'(mac_a[23:16]) + ACC_W'(mac_a[15:8])
              + ACC_W'(mac_a[7:0])) * ACC_W'(mac_b);
  end
  assign mac_c = model_acc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_en) begin
      en_total    <= en_total + 1;
      last_en_cyc <= cyc;
    end
    if (mac_clr) clr_total <= clr_total + 1;
    if (mac_clr)     model_acc <= mac_cfg[ACC_W+2:3];
    else if (mac_en) model_acc <= (mac_cfg[MAC_ACC_SEL_BIT] ? model_acc : '0) + prod;
  end

  typedef struct {
    logic [1:0]       mode;
    logic             acc;
    logic [ACC_W-1:0] init;
    logic [CNT_W-1:0] count;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [ACC_W-1:0] exp_data;
    logic             exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_op_ready"},  64'(op_ready),  64'd0);
    check({tag, "_mac_clr"},   64'(mac_clr),   64'd0);
    check({tag, "_mac_en"},    64'(mac_en),    64'd0);
    check({tag, "_mac_cfg"},   64'(mac_cfg),   64'd0);
    check({tag, "_res_data"},  64'(res_data),  64'd0);
    check({tag, "_res_err"},   64'(res_err),   64'd0);
  endtask

  task automatic start_cmd(input string tag, input logic [1:0] m, input logic ac,
                           input logic [ACC_W-1:0] ini, input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = m; cmd_acc = ac; cmd_init = ini; cmd_count = cnt;
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_beat(input string tag, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    op_valid = 1'b1; op_a = {4{a}}; op_b = b;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) check({tag, "_beat_to"}, 64'(op_ready), 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_res_to"}, 64'(res_valid), 64'd1);
  endtask

  task automatic release_res(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_rel_valid"},   64'(res_valid), 64'd0);
    check({tag, "_rel_busy"},    64'(busy),      64'd0);
    check({tag, "_rel_cmd_rdy"}, 64'(cmd_ready), 64'd1);
    check({tag, "_rel_cfg"},     64'(mac_cfg),   64'd0);
  endtask

  task automatic run_job(input vec_t v, input int idx);
    int    en0, clr0, hs;
    logic  legal_run;
    string tag;
    tag = $sformatf("v%0d", idx);
    legal_run = (v.mode != MAC_ILLEGAL) && (v.count != '0);
    en0 = en_total; clr0 = clr_total;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = v.mode; cmd_acc = v.acc; cmd_init = v.init; cmd_count = v.count;
    op_valid = 1'b1; op_a = {4{v.a}}; op_b = v.b;
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    hs = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (legal_run) begin
      check({tag, "_load_clr"}, 64'(mac_clr), 64'd1);
      check({tag, "_load_cfg"}, 64'(mac_cfg), 64'({v.init, v.acc, v.mode}));
    end else begin
      check({tag, "_skip_opr"}, 64'(op_ready), 64'd0);
    end
    wait_res(tag);
    op_valid = 1'b0;
    check({tag, "_data"}, 64'(res_data), 64'(v.exp_data));
    check({tag, "_err"},  64'(res_err),  64'(v.exp_err));
    check({tag, "_en_n"}, 64'(en_total - en0),  legal_run ? 64'(v.count) : 64'd0);
    check({tag, "_clr_n"}, 64'(clr_total - clr0), legal_run ? 64'd1 : 64'd0);
    if (legal_run) check({tag, "_lat"}, 64'(cyc - last_en_cyc), 64'(LAT + 1));
    else           check({tag, "_lat"}, 64'(cyc - hs), 64'd1);
    release_res(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int en0, clr0;
    logic [ACC_W-1:0] held;

    //            mode         acc init    count   a   b   exp_data err
    vecs[0] = '{MAC_SINGLE,  1'b0, 32'd0,   8'd1,   7,  6,  32'd42,  1'b0};
    vecs[1] = '{MAC_SINGLE,  1'b1, 32'd100, 8'd0,   0,  0,  32'd100, 1'b0};
    vecs[2] = '{MAC_SINGLE,  1'b0, 32'd77,  8'd0,   0,  0,  32'd0,   1'b0};
    vecs[3] = '{MAC_ILLEGAL, 1'b1, 32'd55,  8'd3,   1,  1,  32'd0,   1'b1};
    vecs[4] = '{MAC_SINGLE,  1'b1, 32'd10,  8'd4,   3,  5,  32'd70,  1'b0};
    vecs[5] = '{MAC_SINGLE,  1'b0, 32'd0,   8'd3,   9,  9,  32'd81,  1'b0};
    vecs[6] = '{MAC_DUAL,    1'b1, 32'd1,   8'd2,   2,  3,  32'd25,  1'b0};
    vecs[7] = '{MAC_QUAD,    1'b0, 32'd0,   8'd2,   1,  2,  32'd8,   1'b0};
    vecs[8] = '{MAC_SINGLE,  1'b1, 32'd0,   8'd255, 1,  1,  32'd255, 1'b0};
    vecs[9] = '{MAC_SINGLE,  1'b0, 32'd0,   8'd255, 1,  1,  32'd1,   1'b0};

    rst = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_acc = 1'b0; cmd_init = '0; cmd_count = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst = 1'b1;

    // Three distinct accumulated beats on the A3 lane.
    en0 = en_total; clr0 = clr_total;
    start_cmd("t1", MAC_SINGLE, 1'b1, 32'd5, 8'd3);
    drive_beat("t1", 8'd2, 8'd3);
    drive_beat("t1", 8'd4, 8'd5);
    drive_beat("t1", 8'd1, 8'd1);
    wait_res("t1");
    check("t1_data",  64'(res_data), 64'd32);
    check("t1_err",   64'(res_err),  64'd0);
    check("t1_en_n",  64'(en_total - en0),  64'd3);
    check("t1_clr_n", 64'(clr_total - clr0), 64'd1);
    check("t1_lat",   64'(cyc - last_en_cyc), 64'(LAT + 1));
    release_res("t1");

    for (int i = 0; i < 10; i++) run_job(vecs[i], i);

    // Gappy operand stream, then result backpressure with a competing command.
    en0 = en_total; clr0 = clr_total;
    start_cmd("t4", MAC_SINGLE, 1'b1, 32'd0, 8'd4);
    drive_beat("t4", 8'd1, 8'd2);
    idle_cycle();
    check("t4_cmd_rdy_run", 64'(cmd_ready), 64'd0);
    idle_cycle();
    drive_beat("t4", 8'd2, 8'd2);
    drive_beat("t4", 8'd3, 8'd2);
    idle_cycle();
    drive_beat("t4", 8'd4, 8'd2);
    wait_res("t4");
    held = res_data;
    check("t4_data", 64'(res_data), 64'd20);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = MAC_SINGLE; cmd_acc = 1'b1; cmd_init = 32'd9; cmd_count = 8'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("t4_hold%0d_valid", k), 64'(res_valid), 64'd1);
      check($sformatf("t4_hold%0d_data", k),  64'(res_data),  64'(held));
      check($sformatf("t4_hold%0d_cmdrdy", k), 64'(cmd_ready), 64'd0);
    end
    check("t4_en_n",  64'(en_total - en0),  64'd4);
    check("t4_clr_n", 64'(clr_total - clr0), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("t4_rel_busy",   64'(busy),      64'd0);
    check("t4_rel_cmdrdy", 64'(cmd_ready), 64'd1);
    check("t4_rel_valid",  64'(res_valid), 64'd0);

    // Reset in the middle of a job abandons it.
    start_cmd("t6", MAC_SINGLE, 1'b1, 32'd0, 8'd5);
    drive_beat("t6", 8'd1, 8'd1);
    drive_beat("t6", 8'd1, 8'd1);
    check("t6_busy_mid", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outs("t6");
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("t6_no_res", 64'(res_valid), 64'd0);
    end
    run_job(vecs[4], 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
